tlight_seq: RTL and testbench

TLIGHT_SEQ -- requirements
Module: tlight_seq

---
 rtl/tlight_seq.sv | 152 +++++++++++++++
 tb/tb_tlight_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tlight_seq.sv
// rtl/tlight_seq.sv - frame-paced red/green/yellow traffic-light sequencer
//
// Purpose:
//   Steps RED -> GRN -> YEL -> RED, holding each colour for a configured
//   number of frame_start pulses. Counting only happens on cycles where
//   frame_start and enable are both high. With the pedestrian feature
//   compiled in, a pending request shortens green to MIN_GRN_FRAMES and is
//   acknowledged on the following entry to red.
//
// Configuration:
//   TLIGHT_SEQ_PED_EN - when defined, builds the pedestrian request logic.
//                       When undefined, ped_req is ignored and ped_ack is 0.
//
// Ports:
//   clk           in   single clock
//   reset         in   synchronous active-high reset
//   enable        in   1 = advance on frame_start, 0 = freeze
//   frame_start   in   one-cycle pulse per video frame
//   ped_req       in   pedestrian request (pulse or level)
//   color_sel     out  0 red, 1 yellow, 2 green
//   state_changed out  one-cycle pulse with each color_sel update
//   ped_ack       out  one-cycle pulse when a pending request is served

module tlight_seq #(
    parameter int RED_FRAMES     = 240,
    parameter int GRN_FRAMES     = 240,
    parameter int YEL_FRAMES     = 120,
    parameter int MIN_GRN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_start,
    input  logic       ped_req,
    output logic [1:0] color_sel,
    output logic       state_changed,
    output logic       ped_ack
);

    localparam int MAX_RG     = (RED_FRAMES > GRN_FRAMES) ? RED_FRAMES : GRN_FRAMES;
    localparam int MAX_FRAMES = (MAX_RG > YEL_FRAMES) ? MAX_RG : YEL_FRAMES;
    localparam int CW         = $clog2(MAX_FRAMES + 1);

    localparam logic [CW-1:0] RED_LAST = CW'(RED_FRAMES - 1);
    localparam logic [CW-1:0] GRN_LAST = CW'(GRN_FRAMES - 1);
    localparam logic [CW-1:0] YEL_LAST = CW'(YEL_FRAMES - 1);

    // Encoding matches the colour-mux select so color_sel is the state itself.
    typedef enum logic [1:0] {
        S_RED = 2'd0,
        S_YEL = 2'd1,
        S_GRN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_changed_q, state_changed_d;
    logic          last_frame;
    logic          ped_early;

    // ------------------------------------------------------------------
    // Pedestrian request handling
    // ------------------------------------------------------------------
`ifdef TLIGHT_SEQ_PED_EN
    localparam logic [CW-1:0] MIN_GRN_LAST = CW'(MIN_GRN_FRAMES - 1);

    logic ped_pending_q, ped_pending_d;
    logic ped_ack_q, ped_ack_d;

    // Only the registered pending flag is evaluated, so a request arriving
    // in the same cycle as a counting frame_start takes effect one frame later.
    assign ped_early = ped_pending_q && (cnt_q >= MIN_GRN_LAST);

    always_comb begin
        ped_pending_d = ped_pending_q;
        ped_ack_d     = 1'b0;
        if (state_changed_d && (state_d == S_RED) && ped_pending_q) begin
            ped_pending_d = 1'b0;
            ped_ack_d     = 1'b1;
        end
        // A new request in the serving cycle re-arms pending (set beats clear).
        if (ped_req) begin
            ped_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ped_pending_q <= 1'b0;
            ped_ack_q     <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
            ped_ack_q     <= ped_ack_d;
        end
    end

    assign ped_ack = ped_ack_q;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_early      = 1'b0;
    assign ped_ack        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        state_changed_d = 1'b0;
        last_frame      = 1'b0;

        case (state_q)
            S_RED:   last_frame = (cnt_q == RED_LAST);
            S_GRN:   last_frame = (cnt_q == GRN_LAST) || ped_early;
            S_YEL:   last_frame = (cnt_q == YEL_LAST);
            default: last_frame = 1'b1;
        endcase

        if (frame_start && enable) begin
            if (last_frame) begin
                cnt_d           = '0;
                state_changed_d = 1'b1;
                case (state_q)
                    S_RED:   state_d = S_GRN;
                    S_GRN:   state_d = S_YEL;
                    S_YEL:   state_d = S_RED;
                    default: state_d = S_RED;
                endcase
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_RED;
            cnt_q           <= '0;
            state_changed_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            state_changed_q <= state_changed_d;
        end
    end

    assign color_sel     = state_q;
    assign state_changed = state_changed_q;

endmodule

// File: tb/tb_tlight_seq.sv
// tb/tb_tlight_seq.sv - self-checking bench for tlight_seq

module tb_tlight_seq;

`ifdef TLIGHT_SEQ_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       frame_start = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] color_sel;
    logic       state_changed;
    logic       ped_ack;

    int n_tests = 0;
    int n_fail  = 0;

    tlight_seq #(
        .RED_FRAMES    (3),
        .GRN_FRAMES    (4),
        .YEL_FRAMES    (2),
        .MIN_GRN_FRAMES(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .frame_start  (frame_start),
        .ped_req      (ped_req),
        .color_sel    (color_sel),
        .state_changed(state_changed),
        .ped_ack      (ped_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       fs;
        bit       en;
        bit       pr;
        bit [1:0] ec;
        bit       esc;
        bit       eack;
    } vec_t;

    typedef struct {
        bit [1:0] ec;
        bit       esc;
        bit       eack;
        string    nm;
    } exp_t;

    exp_t exp_q[$];

    task automatic check_one(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic step(input bit rst, input bit fs, input bit en, input bit pr,
                        input bit [1:0] ec, input bit esc, input bit eack,
                        input string nm);
        exp_t e;
        reset       = rst;
        frame_start = fs;
        enable      = en;
        ped_req     = pr;
        exp_q.push_back('{ec, esc, eack, nm});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_one({nm, "_sb_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_one({e.nm, "_color"}, int'(color_sel), int'(e.ec));
            check_one({e.nm, "_chg"}, int'(state_changed), int'(e.esc));
            check_one({e.nm, "_ack"}, int'(ped_ack), int'(e.eack));
        end
    endtask

    task automatic fr(input bit pr, input bit [1:0] ec, input bit esc,
                      input bit eack, input string nm);
        step(1'b0, 1'b1, 1'b1, pr, ec, esc, eack, nm);
    endtask

    task automatic idle(input bit pr, input bit [1:0] ec, input string nm);
        step(1'b0, 1'b0, 1'b1, pr, ec, 1'b0, 1'b0, nm);
    endtask

    task automatic do_reset(input string nm);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, {nm, "_rst"});
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, {nm, "_rel"});
    endtask

    task automatic to_green(input string nm);
        fr(1'b0, 2'd0, 1'b0, 1'b0, {nm, "_r1"});
        fr(1'b0, 2'd0, 1'b0, 1'b0, {nm, "_r2"});
        fr(1'b0, 2'd2, 1'b1, 1'b0, {nm, "_r3"});
    endtask

    vec_t tbl[17];

    initial begin
        // Reset, ignored inputs during reset, then nine frames of a full cycle.
        tbl = '{
            '{1, 0, 1, 0, 2'd0, 0, 0},
            '{1, 1, 1, 1, 2'd0, 0, 0},
            '{0, 0, 1, 0, 2'd0, 0, 0},
            '{0, 1, 1, 0, 2'd0, 0, 0},
            '{0, 0, 1, 0, 2'd0, 0, 0},
            '{0, 1, 1, 0, 2'd0, 0, 0},
            '{0, 0, 1, 0, 2'd0, 0, 0},
            '{0, 1, 1, 0, 2'd2, 1, 0},
            '{0, 0, 1, 0, 2'd2, 0, 0},
            '{0, 1, 1, 0, 2'd2, 0, 0},
            '{0, 1, 1, 0, 2'd2, 0, 0},
            '{0, 1, 1, 0, 2'd2, 0, 0},
            '{0, 1, 1, 0, 2'd1, 1, 0},
            '{0, 0, 1, 0, 2'd1, 0, 0},
            '{0, 1, 1, 0, 2'd1, 0, 0},
            '{0, 1, 1, 0, 2'd0, 1, 0},
            '{0, 0, 1, 0, 2'd0, 0, 0}
        };

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst, tbl[i].fs, tbl[i].en, tbl[i].pr,
                 tbl[i].ec, tbl[i].esc, tbl[i].eack, $sformatf("cyc_v%0d", i));
        end

        // Request after green entry: early exit, ack on next red entry.
        do_reset("g30");
        to_green("g30");
        idle(1'b1, 2'd2, "g30_req");
        fr(1'b0, PED ? 2'd1 : 2'd2, PED, 1'b0, "g30_f4");
        fr(1'b0, PED ? 2'd1 : 2'd2, 1'b0, 1'b0, "g30_f5");
        fr(1'b0, PED ? 2'd0 : 2'd2, PED, PED, "g30_f6");
        idle(1'b0, PED ? 2'd0 : 2'd2, "g30_after");

        // Two requests in red: one-frame green, single ack, pending cleared.
        do_reset("r31");
        idle(1'b1, 2'd0, "r31_req1");
        idle(1'b1, 2'd0, "r31_req2");
        to_green("r31");
        fr(1'b0, PED ? 2'd1 : 2'd2, PED, 1'b0, "r31_f4");
        fr(1'b0, PED ? 2'd1 : 2'd2, 1'b0, 1'b0, "r31_f5");
        fr(1'b0, PED ? 2'd0 : 2'd2, PED, PED, "r31_f6");
        idle(1'b0, PED ? 2'd0 : 2'd2, "r31_idle");
        fr(1'b0, PED ? 2'd0 : 2'd1, !PED, 1'b0, "r31_f7");
        fr(1'b0, PED ? 2'd0 : 2'd1, 1'b0, 1'b0, "r31_f8");
        fr(1'b0, PED ? 2'd2 : 2'd0, 1'b1, 1'b0, "r31_f9");
        fr(1'b0, PED ? 2'd2 : 2'd0, 1'b0, 1'b0, "r31_f10");

        // Request coincident with a counting frame is only seen a frame later.
        do_reset("c20");
        to_green("c20");
        fr(1'b1, 2'd2, 1'b0, 1'b0, "c20_same");
        fr(1'b0, PED ? 2'd1 : 2'd2, PED, 1'b0, "c20_next");

        // Freeze with enable low in green, then resume.
        do_reset("e32");
        to_green("e32");
        fr(1'b0, 2'd2, 1'b0, 1'b0, "e32_g1");
        fr(1'b0, 2'd2, 1'b0, 1'b0, "e32_g2");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, $sformatf("e32_frz%0d", i));
        end
        fr(1'b0, 2'd2, 1'b0, 1'b0, "e32_g3");
        fr(1'b0, 2'd1, 1'b1, 1'b0, "e32_yel");

        // Reset with a request pending discards it; a full red follows.
        do_reset("x33");
        to_green("x33");
        idle(1'b1, 2'd2, "x33_req");
        fr(1'b0, PED ? 2'd1 : 2'd2, PED, 1'b0, "x33_f4");
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, "x33_rst");
        idle(1'b0, 2'd0, "x33_rel");
        fr(1'b0, 2'd0, 1'b0, 1'b0, "x33_r1");
        fr(1'b0, 2'd0, 1'b0, 1'b0, "x33_r2");
        fr(1'b0, 2'd2, 1'b1, 1'b0, "x33_r3");
        fr(1'b0, 2'd2, 1'b0, 1'b0, "x33_g1");

        // Request held high throughout.
        do_reset("h34");
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, "h34_r1");
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, "h34_r2");
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, "h34_r3");
        fr(1'b1, PED ? 2'd1 : 2'd2, PED, 1'b0, "h34_f4");
        fr(1'b1, PED ? 2'd1 : 2'd2, 1'b0, 1'b0, "h34_f5");
        fr(1'b1, PED ? 2'd0 : 2'd2, PED, PED, "h34_f6");
        fr(1'b1, PED ? 2'd0 : 2'd1, !PED, 1'b0, "h34_f7");
        idle(1'b0, PED ? 2'd0 : 2'd1, "h34_end");

        check_one("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
